// File: rtl/low_contrast_reject.sv
// low_contrast_reject: rejects low-contrast and singular-Hessian keypoint
// candidates. Survivors are queued in a first-word-fall-through FIFO that the
// descriptor stage drains through a valid/ready handshake.
// Optional feature: define LCR_STATS_EN to build the kept/rejected counters.
// Without it, ocnt_kept and ocnt_rejected are tied to zero.
module low_contrast_reject #(
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned THR_SQ     = 58,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            iclk,
  input  logic                            irst_n,
  input  logic                            ivalid,
  input  logic signed [31:0]              ileft_value,
  input  logic signed [31:0]              iright_value,
  input  logic                            iedge_pass,
  input  logic [COORD_W-1:0]              ix,
  input  logic [COORD_W-1:0]              iy,
  output logic                            okp_valid,
  input  logic                            ikp_ready,
  output logic [COORD_W-1:0]              okp_x,
  output logic [COORD_W-1:0]              okp_y,
  output logic [$clog2(FIFO_DEPTH):0]     ofifo_count,
  output logic                            ooverflow,
  input  logic                            iclr_ovf,
  output logic [15:0]                     ocnt_kept,
  output logic [15:0]                     ocnt_rejected
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 2 * COORD_W;

  // ---------------------------------------------------------------------------
  // Stage 1: widen both sides of the contrast inequality to 64 bit and
  // capture the sign flags used to reject degenerate candidates.
  // ---------------------------------------------------------------------------
  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_edge_q,  s1_edge_d;
  logic                      s1_neg_q,   s1_neg_d;
  logic                      s1_lneg_q,  s1_lneg_d;
  logic signed [63:0]        s1_prod_q,  s1_prod_d;
  logic signed [63:0]        s1_thr_q,   s1_thr_d;
  logic [COORD_W-1:0]        s1_x_q,     s1_x_d;
  logic [COORD_W-1:0]        s1_y_q,     s1_y_d;

  // Stage-1 next values: sign-extended products and rejection flags.
  always_comb begin
    s1_valid_d = ivalid;
    s1_edge_d  = iedge_pass;
    s1_neg_d   = (iright_value <= 32'sd0);
    s1_lneg_d  = (ileft_value < 32'sd0);
    s1_prod_d  = $signed({{32{ileft_value[31]}}, ileft_value});
    s1_thr_d   = $signed({{32{iright_value[31]}}, iright_value}) * $signed(64'(THR_SQ));
    s1_x_d     = ix;
    s1_y_d     = iy;
  end

  // Stage-1 pipeline register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_valid_q <= 1'b0;
      s1_edge_q  <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_lneg_q  <= 1'b0;
      s1_prod_q  <= '0;
      s1_thr_q   <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_edge_q  <= s1_edge_d;
      s1_neg_q   <= s1_neg_d;
      s1_lneg_q  <= s1_lneg_d;
      s1_prod_q  <= s1_prod_d;
      s1_thr_q   <= s1_thr_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: keep decision. Equality with the threshold rejects.
  // ---------------------------------------------------------------------------
  logic keep;

  // Strict signed compare plus validity, edge and sign gating.
  always_comb begin
    keep = s1_valid_q & s1_edge_q & ~s1_neg_q & ~s1_lneg_q & (s1_prod_q > s1_thr_q);
  end

  // ---------------------------------------------------------------------------
  // Keypoint FIFO: storage array followed by a registered head slot. The head
  // slot gives the one-cycle write-to-visible delay (no bypass) and keeps
  // okp_x/okp_y stable while the consumer stalls. ofifo_count covers both the
  // array and the head slot, so capacity is FIFO_DEPTH entries in total.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q,    wptr_d;
  logic [AW-1:0]  rptr_q,    rptr_d;
  logic [CW-1:0]  mem_cnt_q, mem_cnt_d;
  logic [CW-1:0]  count_q,   count_d;
  logic           head_vld_q, head_vld_d;
  logic [COORD_W-1:0] head_x_q, head_x_d;
  logic [COORD_W-1:0] head_y_q, head_y_d;
  logic           ovf_q,     ovf_d;

  logic           pop;
  logic           full;
  logic           push;
  logic           drop;
  logic           load;
  logic [DW-1:0]  rd_data;

  // FIFO control: pointer/count bookkeeping, head reload and sticky overflow.
  always_comb begin
    pop        = head_vld_q & ikp_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    push       = keep & (~full | pop);
    drop       = keep & full & ~pop;
    load       = (mem_cnt_q != '0) & (~head_vld_q | pop);
    rd_data    = mem_q[rptr_q];

    wptr_d     = wptr_q + AW'(push);
    rptr_d     = rptr_q + AW'(load);
    mem_cnt_d  = mem_cnt_q + CW'(push) - CW'(load);
    count_d    = count_q + CW'(push) - CW'(pop);

    head_vld_d = head_vld_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    if (load) begin
      head_vld_d = 1'b1;
      head_x_d   = rd_data[DW-1:COORD_W];
      head_y_d   = rd_data[COORD_W-1:0];
    end else if (pop) begin
      head_vld_d = 1'b0;
    end

    // A drop in the same cycle as the clear leaves the flag set.
    ovf_d = drop | (ovf_q & ~iclr_ovf);
  end

  // FIFO state register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
      head_x_q   <= '0;
      head_y_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      count_q    <= count_d;
      head_vld_q <= head_vld_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage array write port; contents are don't-care until counted valid.
  always_ff @(posedge iclk) begin
    if (push) begin
      mem_q[wptr_q] <= {s1_x_q, s1_y_q};
    end
  end

  assign okp_valid   = head_vld_q;
  assign okp_x       = head_x_q;
  assign okp_y       = head_y_q;
  assign ofifo_count = count_q;
  assign ooverflow   = ovf_q;

  // ---------------------------------------------------------------------------
  // Optional statistics counters.
  // ---------------------------------------------------------------------------
`ifdef LCR_STATS_EN
  logic [15:0] cnt_kept_q, cnt_kept_d;
  logic [15:0] cnt_rej_q,  cnt_rej_d;
  logic        reject;

  // Saturating kept/rejected counters; iclr_ovf clears both.
  always_comb begin
    reject     = s1_valid_q & ~keep;
    cnt_kept_d = cnt_kept_q;
    cnt_rej_d  = cnt_rej_q;
    if (iclr_ovf) begin
      cnt_kept_d = '0;
      cnt_rej_d  = '0;
    end else begin
      if (keep && (cnt_kept_q != '1)) cnt_kept_d = cnt_kept_q + 16'd1;
      if (reject && (cnt_rej_q != '1)) cnt_rej_d = cnt_rej_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_kept_q <= '0;
      cnt_rej_q  <= '0;
    end else begin
      cnt_kept_q <= cnt_kept_d;
      cnt_rej_q  <= cnt_rej_d;
    end
  end

  assign ocnt_kept     = cnt_kept_q;
  assign ocnt_rejected = cnt_rej_q;
`else
  assign ocnt_kept     = '0;
  assign ocnt_rejected = '0;
`endif

endmodule

// File: tb/tb_low_contrast_reject.sv
// Directed self-checking bench for low_contrast_reject.
// Honours LCR_STATS_EN when checking the statistics counters.
module tb_low_contrast_reject;

  logic               iclk = 1'b0;
  logic               irst_n;
  logic               ivalid;
  logic signed [31:0] ileft_value;
  logic signed [31:0] iright_value;
  logic               iedge_pass;
  logic [9:0]         ix;
  logic [9:0]         iy;
  logic               okp_valid;
  logic               ikp_ready;
  logic [9:0]         okp_x;
  logic [9:0]         okp_y;
  logic [4:0]         ofifo_count;
  logic               ooverflow;
  logic               iclr_ovf;
  logic [15:0]        ocnt_kept;
  logic [15:0]        ocnt_rejected;

  int vectors = 0;
  int miscompares = 0;

  low_contrast_reject #(
    .COORD_W    (10),
    .THR_SQ     (58),
    .FIFO_DEPTH (16)
  ) dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .ivalid        (ivalid),
    .ileft_value   (ileft_value),
    .iright_value  (iright_value),
    .iedge_pass    (iedge_pass),
    .ix            (ix),
    .iy            (iy),
    .okp_valid     (okp_valid),
    .ikp_ready     (ikp_ready),
    .okp_x         (okp_x),
    .okp_y         (okp_y),
    .ofifo_count   (ofifo_count),
    .ooverflow     (ooverflow),
    .iclr_ovf      (iclr_ovf),
    .ocnt_kept     (ocnt_kept),
    .ocnt_rejected (ocnt_rejected)
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cand(input int l, input int r, input logic e, input int x, input int y);
    ivalid       = 1'b1;
    ileft_value  = l;
    iright_value = r;
    iedge_pass   = e;
    ix           = 10'(x);
    iy           = 10'(y);
  endtask

  initial begin
    irst_n = 1'b0; ivalid = 1'b0; ileft_value = '0; iright_value = '0;
    iedge_pass = 1'b0; ix = '0; iy = '0; ikp_ready = 1'b0; iclr_ovf = 1'b0;
    step(); step();
    irst_n = 1'b1;
    step();

    // Reset state
    chk("rst_valid", okp_valid, 0);
    chk("rst_x", okp_x, 0);
    chk("rst_y", okp_y, 0);
    chk("rst_count", ofifo_count, 0);
    chk("rst_ovf", ooverflow, 0);
    chk("rst_kept", ocnt_kept, 0);
    chk("rst_rej", ocnt_rejected, 0);

    // T1 latency: visible exactly 3 clocks after ivalid
    cand(10000, 100, 1'b1, 5, 7);
    step();                       // clock 1: stage 1
    ivalid = 1'b0;
    step();                       // clock 2: FIFO write
    chk("t1_valid_c2", okp_valid, 0);
    chk("t1_count_c2", ofifo_count, 1);
    step();                       // clock 3: head visible
    chk("t1_valid_c3", okp_valid, 1);
    chk("t1_x", okp_x, 5);
    chk("t1_y", okp_y, 7);
    step();                       // stalled consumer: head held
    chk("t1_hold_valid", okp_valid, 1);
    chk("t1_hold_x", okp_x, 5);
    ikp_ready = 1'b1;
    step();
    ikp_ready = 1'b0;
    chk("t1_pop_valid", okp_valid, 0);
    chk("t1_pop_count", ofifo_count, 0);

    // T2 threshold and rejection conditions; only x=2 and x=6 survive
    cand(5800, 100, 1'b1, 1, 1);       step();  // equality rejects
    cand(5801, 100, 1'b1, 2, 2);       step();  // just above: kept
    cand(-1, 100, 1'b1, 3, 3);         step();  // negative left
    cand(1000000, 0, 1'b1, 4, 4);      step();  // zero det
    cand(1000000, 100, 1'b0, 5, 5);    step();  // edge test failed
    cand(1000000, -5, 1'b1, 7, 7);     step();  // negative det
    cand(1000000, 100, 1'b1, 6, 9);    step();  // kept
    ivalid = 1'b0;
    step(); step(); step();
    chk("t2_count", ofifo_count, 2);
    chk("t2_head_x", okp_x, 2);
    chk("t2_head_y", okp_y, 2);
    ikp_ready = 1'b1;
    step();
    ikp_ready = 1'b0;
    chk("t2_second_x", okp_x, 6);
    chk("t2_second_y", okp_y, 9);
    chk("t2_count1", ofifo_count, 1);
    ikp_ready = 1'b1;
    step();
    ikp_ready = 1'b0;
    chk("t2_empty_count", ofifo_count, 0);
    chk("t2_empty_valid", okp_valid, 0);
    chk("t2_ovf", ooverflow, 0);

    // T3 overflow: 17 kept candidates with the consumer stalled
    for (int i = 0; i < 17; i++) begin
      cand(10000, 100, 1'b1, 10 + i, i);
      step();
    end
    ivalid = 1'b0;
    step(); step(); step();
    chk("t3_count", ofifo_count, 16);
    chk("t3_ovf", ooverflow, 1);
    chk("t3_head_x", okp_x, 10);
    chk("t3_head_y", okp_y, 0);
    iclr_ovf = 1'b1;
    step();
    iclr_ovf = 1'b0;
    chk("t3_clr_ovf", ooverflow, 0);
    chk("t3_clr_count", ofifo_count, 16);

    // T4 full FIFO: a keep lands on the same edge as a pop
    cand(10000, 100, 1'b1, 100, 50);
    step();
    ivalid = 1'b0;
    ikp_ready = 1'b1;
    step();                       // push and pop together while full
    chk("t4_count", ofifo_count, 16);
    chk("t4_ovf", ooverflow, 0);
    for (int i = 0; i < 15; i++) begin
      chk("t4_order_x", okp_x, 64'(11 + i));
      step();
    end
    chk("t4_new_x", okp_x, 100);
    chk("t4_new_y", okp_y, 50);
    chk("t4_new_count", ofifo_count, 1);
    step();
    ikp_ready = 1'b0;
    chk("t4_empty_count", ofifo_count, 0);
    chk("t4_empty_valid", okp_valid, 0);

    // T5 reset with 5 stored entries and 2 candidates in flight
    for (int i = 0; i < 6; i++) begin
      cand(10000, 100, 1'b1, 200 + i, i);
      step();
    end
    chk("t5_pre_count", ofifo_count, 5);
    cand(10000, 100, 1'b1, 210, 10);
    irst_n = 1'b0;
    #1;
    chk("t5_async_count", ofifo_count, 0);
    chk("t5_async_valid", okp_valid, 0);
    ivalid = 1'b0;
    step(); step();
    irst_n = 1'b1;
    step(); step(); step(); step();
    chk("t5_post_count", ofifo_count, 0);
    chk("t5_post_valid", okp_valid, 0);
    chk("t5_post_ovf", ooverflow, 0);

    // T6 statistics: 300 candidates, 2 of every 5 kept
    ikp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case (i % 5)
        0, 1:    cand(9000, 100, 1'b1, i % 1024, 1);
        2:       cand(5800, 100, 1'b1, 0, 0);
        3:       cand(9000, 100, 1'b0, 0, 0);
        default: cand(9000, -3, 1'b1, 0, 0);
      endcase
      step();
    end
    ivalid = 1'b0;
    step(); step(); step();
    ikp_ready = 1'b0;
`ifdef LCR_STATS_EN
    chk("t6_kept", ocnt_kept, 120);
    chk("t6_rejected", ocnt_rejected, 180);
`else
    chk("t6_kept", ocnt_kept, 0);
    chk("t6_rejected", ocnt_rejected, 0);
`endif
    chk("t6_ovf", ooverflow, 0);
    chk("t6_count", ofifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
